cla_accumulator: RTL and testbench
==================================

Name: cla_accumulator

Overview:
- Sequential stage wrapped around the combinational BITS-wide CLA adder.
- Accepts a burst of LEN operands over a valid/ready stream and sums them into a registered accumulator.
- Presents the final sum, a sticky overflow flag and the beat count on a valid/ready output.
- Sits between the icestick operand source (UART/switch capture) and the display/TX path; it is the register-and-control layer the combinational adder lacks.

Parameters:
- BITS, 8, operand and accumulator width.
- COUNT_W, 8, width of burst length and beat counter (max burst 2^COUNT_W-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a burst; honoured only in IDLE or on the DONE-exit cycle.
- len  in  COUNT_W  number of operands in the burst; sampled with start.
- abort  in  1  synchronous clear; returns the block to IDLE from any state.
- in_valid  in  1  operand valid.
- in_ready  out  1  high exactly while state==ACC (decoded from state, not registered).
- in_data  in  BITS  operand.
- out_valid  out  1  result valid; high exactly in DONE.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  BITS  accumulated sum (registered).
- out_ovf  out  1  sticky: any carry-out (or saturation event) during the burst.
- out_count  out  COUNT_W  beats accepted in the burst.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE.
  - acc, cnt, len_q, out_sum, out_ovf, out_count all = 0.
  - in_ready=0, out_valid=0.
- States: IDLE, ACC, DONE; 2-bit encoding.
- IDLE:
  - start with len!=0: len_q<=len, acc<=0, cnt<=0, ovf<=0; next state ACC.
  - start with len==0: acc<=0, cnt<=0, ovf<=0; next state DONE. The output is sum 0, count 0.
- ACC, on each beat (in_valid & in_ready):
  - {carry, acc} <= acc + in_data, computed BITS+1 wide through the adder with cin=0.
  - ovf <= ovf | carry.
  - cnt <= cnt+1.
- ACC, last beat (cnt==len_q-1 on an accepted beat): next state DONE. The result is visible on out_* one cycle after the last beat; there are no extra pipeline stages.
- ACC with in_valid low: hold all state; there is no timeout.
- DONE:
  - out_valid=1; out_sum=acc, out_ovf=ovf, out_count=cnt, all stable while out_ready is low.
  - out_ready high: next state IDLE; out_valid drops the following cycle.
  - out_ready and start high in the same cycle: the handshake completes and the new burst starts at once, i.e. next state ACC (or DONE again if len==0). There is no idle bubble.
- start while in ACC or DONE (without out_ready): ignored; no error flag.
- abort:
  - Highest priority after reset.
  - Next state IDLE; acc/cnt/ovf cleared; out_* cleared.
  - Any in-flight beat in the same cycle is discarded.
- Width rules:
  - Arithmetic is modulo 2^BITS unless SATURATE_EN is defined.
  - The counter never wraps, because len_q bounds it.

Optional Feature:
- Macro: CLA_ACC_SATURATE_EN.
- Defined: on carry-out, acc <= all-ones and holds at all-ones for the rest of the burst; out_ovf is still set.
- Undefined: acc wraps modulo 2^BITS; out_ovf records the carry.

Decomposition:
- Shared package cla_pkg holds:
  - state enum constants ST_IDLE=2'd0, ST_ACC=2'd1, ST_DONE=2'd2;
  - default widths CLA_BITS=8, CLA_COUNT_W=8.
- One natural sub-module: cla_acc_adder, a BITS+1-bit wrapper.
  - Feeds acc and in_data into the CLA adder.
  - Returns sum and carry-out.
  - Keeps the datapath separate from the FSM.

Test Plan:
- Basic burst (BITS=8): start, len=3; operands 10, 20, 30 with in_valid held high → out_valid asserts 1 cycle after the third beat; out_sum=60, out_count=3, out_ovf=0.
- Overflow: len=2, operands 200 and 100 → out_sum=44, out_ovf=1. With CLA_ACC_SATURATE_EN → out_sum=255, out_ovf=1.
- Backpressure/bubbles: len=4 with in_valid toggling every other cycle, then out_ready held low 5 cycles → out_valid remains high, out_sum=sum of the 4 operands stable throughout, in_ready=0 in DONE.
- Zero length and back-to-back:
  - start with len=0 → DONE next cycle, out_sum=0, out_count=0.
  - Assert out_ready together with start, len=1, operand 7 → next result is 7 with no IDLE cycle between.
- Abort and reset mid-burst:
  - abort after 2 of 5 beats → IDLE next cycle; in_ready=0; a new burst of 1 operand (5) then reports out_sum=5.
  - rst_n low asynchronously mid-ACC → all outputs 0 immediately.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the CLA accumulator: FSM state encoding and default widths.
package cla_pkg;

  localparam int CLA_BITS    = 8;
  localparam int CLA_COUNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } cla_state_t;

endpackage

// File: rtl/cla_acc_adder.sv
// BITS+1-wide carry-lookahead datapath: returns a + b with carry-out, carry-in fixed at 0.
module cla_acc_adder
  import cla_pkg::*;
#(
  parameter int BITS = CLA_BITS
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] sum,
  output logic            cout
);

  logic [BITS-1:0] gen;
  logic [BITS-1:0] prop;
  logic [BITS:0]   carry;

  // Carries built from generate/propagate terms; synthesis flattens the chain into lookahead logic.
  always_comb begin
    gen      = a & b;
    prop     = a ^ b;
    carry    = '0;
    carry[0] = 1'b0;
    for (int i = 0; i < BITS; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
    sum  = prop ^ carry[BITS-1:0];
    cout = carry[BITS];
  end

endmodule

// File: rtl/cla_accumulator.sv
// Burst accumulator around the CLA adder with valid/ready input and output streams.
// Optional macro CLA_ACC_SATURATE_EN clamps the accumulator to all-ones on carry-out.
module cla_accumulator
  import cla_pkg::*;
#(
  parameter int BITS    = CLA_BITS,
  parameter int COUNT_W = CLA_COUNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITS-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITS-1:0]    out_sum,
  output logic               out_ovf,
  output logic [COUNT_W-1:0] out_count
);

  cla_state_t state, state_next;

  logic [BITS-1:0]    acc;
  logic [BITS-1:0]    acc_next;
  logic [BITS-1:0]    add_sum;
  logic               add_cout;
  logic               ovf;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] len_q;
  logic               beat;
  logic               last_beat;
  logic               take_start;

  cla_acc_adder #(.BITS(BITS)) u_adder (
    .a    (acc),
    .b    (in_data),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // A new burst may begin from IDLE or on the same cycle the result is handed off.
  assign take_start = start && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign beat       = in_valid && in_ready;
  assign last_beat  = beat && (cnt == len_q - COUNT_W'(1));

`ifdef CLA_ACC_SATURATE_EN
  assign acc_next = add_cout ? {BITS{1'b1}} : add_sum;
`else
  assign acc_next = add_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (take_start) state_next = (len == '0) ? ST_DONE : ST_ACC;
      ST_ACC:  if (last_beat)  state_next = ST_DONE;
      ST_DONE: begin
        if (take_start)     state_next = (len == '0) ? ST_DONE : ST_ACC;
        else if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  always_comb begin
    in_ready  = (state == ST_ACC);
    out_valid = (state == ST_DONE);
  end

  // Result registers are loaded as DONE is entered, so they stay frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      len_q     <= '0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else if (abort) begin
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      len_q     <= '0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else if (take_start) begin
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
      len_q <= len;
      if (len == '0) begin
        out_sum   <= '0;
        out_ovf   <= 1'b0;
        out_count <= '0;
      end
    end else if (beat) begin
      acc <= acc_next;
      ovf <= ovf | add_cout;
      cnt <= cnt + COUNT_W'(1);
      if (last_beat) begin
        out_sum   <= acc_next;
        out_ovf   <= ovf | add_cout;
        out_count <= cnt + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cla_accumulator.sv
// Self-checking bench for cla_accumulator: vector table, corner-case sequences and random bursts.
module tb_cla_accumulator;

  localparam int BITS    = 8;
  localparam int COUNT_W = 8;
  localparam int MAXV    = (1 << BITS) - 1;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [COUNT_W-1:0] len;
  logic               abort;
  logic               in_valid;
  logic               in_ready;
  logic [BITS-1:0]    in_data;
  logic               out_valid;
  logic               out_ready;
  logic [BITS-1:0]    out_sum;
  logic               out_ovf;
  logic [COUNT_W-1:0] out_count;

  int errors;
  int checks;

  logic [BITS-1:0] burst_ops [64];

  typedef struct packed {
    logic [7:0]      n;
    logic [3:0][7:0] ops;
    logic            gaps;
    logic [3:0]      hold;
    logic [7:0]      sum;
    logic            ovf;
  } vec_t;

  vec_t vecs [5];

  cla_accumulator #(.BITS(BITS), .COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Sum and sticky carry derived from plain integer arithmetic over the operand list.
  function automatic void model(input int n, output int exp_sum, output int exp_ovf);
    int acc;
    acc     = 0;
    exp_ovf = 0;
    for (int i = 0; i < n; i++) begin
      acc += int'(burst_ops[i]);
      if (acc > MAXV) begin
        exp_ovf = 1;
`ifdef CLA_ACC_SATURATE_EN
        acc = MAXV;
`else
        acc -= MAXV + 1;
`endif
      end
    end
    exp_sum = acc;
  endfunction

  task automatic applyStimulus(input int n, input bit gaps);
    start = 1'b1;
    len   = COUNT_W'(n);
    tick();
    start = 1'b0;
    len   = '0;
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = burst_ops[i];
      if (i == 0) checkOutput("in_ready_in_acc", int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic checkResult(input string name, input int exp_sum, input int exp_ovf,
                             input int exp_cnt, input int hold);
    for (int h = 0; h <= hold; h++) begin
      checkOutput({name, "_out_valid"}, int'(out_valid), 1);
      checkOutput({name, "_out_sum"}, int'(out_sum), exp_sum);
      if (h < hold) tick();
    end
    checkOutput({name, "_out_ovf"}, int'(out_ovf), exp_ovf);
    checkOutput({name, "_out_count"}, int'(out_count), exp_cnt);
    checkOutput({name, "_in_ready_done"}, int'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({name, "_valid_drop"}, int'(out_valid), 0);
  endtask

  initial begin
    int exp_sum;
    int exp_ovf;
    int n;
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Concatenations list operands high index first, so ops[0] is the rightmost field.
    vecs[0] = '{n: 8'd3, ops: {8'd0, 8'd30, 8'd20, 8'd10}, gaps: 1'b0, hold: 4'd0, sum: 8'd60, ovf: 1'b0};
`ifdef CLA_ACC_SATURATE_EN
    vecs[1] = '{n: 8'd2, ops: {8'd0, 8'd0, 8'd100, 8'd200}, gaps: 1'b0, hold: 4'd0, sum: 8'd255, ovf: 1'b1};
    vecs[4] = '{n: 8'd4, ops: {8'd0, 8'd1, 8'd128, 8'd128}, gaps: 1'b0, hold: 4'd0, sum: 8'd255, ovf: 1'b1};
`else
    vecs[1] = '{n: 8'd2, ops: {8'd0, 8'd0, 8'd100, 8'd200}, gaps: 1'b0, hold: 4'd0, sum: 8'd44, ovf: 1'b1};
    vecs[4] = '{n: 8'd4, ops: {8'd0, 8'd1, 8'd128, 8'd128}, gaps: 1'b0, hold: 4'd0, sum: 8'd1, ovf: 1'b1};
`endif
    vecs[2] = '{n: 8'd4, ops: {8'd40, 8'd3, 8'd17, 8'd5}, gaps: 1'b1, hold: 4'd5, sum: 8'd65, ovf: 1'b0};
    vecs[3] = '{n: 8'd1, ops: {8'd0, 8'd0, 8'd0, 8'd255}, gaps: 1'b0, hold: 4'd0, sum: 8'd255, ovf: 1'b0};

    #3;
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_in_ready", int'(in_ready), 0);
    checkOutput("reset_out_sum", int'(out_sum), 0);
    checkOutput("reset_out_count", int'(out_count), 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++) burst_ops[i] = vecs[v].ops[i];
      applyStimulus(int'(vecs[v].n), vecs[v].gaps);
      checkResult($sformatf("vec%0d", v), int'(vecs[v].sum), int'(vecs[v].ovf),
                  int'(vecs[v].n), int'(vecs[v].hold));
    end

    // Zero-length burst, then a back-to-back start on the handoff cycle.
    start = 1'b1;
    len   = '0;
    tick();
    start = 1'b0;
    checkOutput("zero_len_valid", int'(out_valid), 1);
    checkOutput("zero_len_sum", int'(out_sum), 0);
    checkOutput("zero_len_count", int'(out_count), 0);
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 8'd1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    len       = '0;
    checkOutput("b2b_no_bubble_ready", int'(in_ready), 1);
    checkOutput("b2b_no_bubble_valid", int'(out_valid), 0);
    in_valid = 1'b1;
    in_data  = 8'd7;
    tick();
    in_valid = 1'b0;
    checkResult("b2b", 7, 0, 1, 0);

    // Abort after two of five beats, with a stray start ignored mid-burst.
    start = 1'b1;
    len   = 8'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd9;
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b1;
    len      = '0;
    tick();
    start = 1'b0;
    checkOutput("start_ignored_in_acc", int'(in_ready), 1);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd50;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    checkOutput("abort_in_ready", int'(in_ready), 0);
    checkOutput("abort_out_valid", int'(out_valid), 0);
    checkOutput("abort_out_sum", int'(out_sum), 0);
    burst_ops[0] = 8'd5;
    applyStimulus(1, 1'b0);
    checkResult("after_abort", 5, 0, 1, 0);

    for (int r = 0; r < 20; r++) begin
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        burst_ops[i] = ($urandom_range(0, 3) == 0) ? BITS'($urandom_range(200, MAXV))
                                                   : BITS'($urandom_range(0, 60));
      end
      model(n, exp_sum, exp_ovf);
      applyStimulus(n, 1'($urandom_range(0, 1)));
      checkResult($sformatf("rand%0d", r), exp_sum, exp_ovf, n, int'($urandom_range(0, 2)));
    end

    // Asynchronous reset in the middle of a burst must clear outputs without a clock edge.
    start = 1'b1;
    len   = 8'd3;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd77;
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("async_rst_in_ready", int'(in_ready), 0);
    checkOutput("async_rst_out_sum", int'(out_sum), 0);
    checkOutput("async_rst_out_count", int'(out_count), 0);
    checkOutput("async_rst_out_valid", int'(out_valid), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
